pss_peak_detector: RTL and testbench
====================================

PSS_PEAK_DETECTOR -- requirements
Module: pss_peak_detector

Interface
REQ-001 SHALL have parameter IN_DW, default 24, width of the unsigned correlator magnitude input.
REQ-002 SHALL have parameter WINDOW_LEN, default 128, moving-average length in samples; must be a power of two, at least 2.
REQ-003 SHALL have parameter DETECTION_SHIFT, default 4, threshold factor as a power of two: detect if sample > average * 2^DETECTION_SHIFT.
REQ-004 SHALL have parameter HOLD_LEN, default 16, number of valid samples searched for a maximum after a candidate; must be at least 1.
REQ-005 SHALL have parameter CNT_DW, default 32, width of the sample index counter.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-007 SHALL have port reset_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port s_axis_in_tdata, input, IN_DW bits: unsigned magnitude from the PSS correlator.
REQ-009 SHALL have port s_axis_in_tvalid, input, 1 bit: marks a valid sample; there is no backpressure.
REQ-010 SHALL have port peak_detected_o, output, 1 bit: single-cycle pulse when a peak is reported.
REQ-011 SHALL have port peak_idx_o, output, CNT_DW bits: sample index of the reported peak.
REQ-012 SHALL have port peak_val_o, output, IN_DW bits: magnitude of the reported peak.
REQ-013 SHALL have port noise_avg_o, output, IN_DW bits: current moving sum >> log2(WINDOW_LEN), registered.

Function
REQ-014 SHALL keep a sample index counter that increments on each valid sample, wraps modulo 2^CNT_DW, and gives index 0 to the first sample after reset.
REQ-015 SHALL keep a ring buffer of the last WINDOW_LEN samples and a moving sum of width IN_DW+log2(WINDOW_LEN), with no overflow possible.
REQ-016 Moving sum update per valid sample:
- WARMUP: sum += in.
- Otherwise: sum += in - oldest.
- The ring buffer contents need no reset.
REQ-017 SHALL have states WARMUP, SEARCH and TRACK; nothing advances on cycles where tvalid is low.
REQ-018 WARMUP: no detection; move to SEARCH after the WINDOW_LEN-th valid sample (index WINDOW_LEN-1) has been absorbed.
REQ-019 Candidate test, in SEARCH, on the sum before the current sample is added: (in << log2(WINDOW_LEN)) > (sum << DETECTION_SHIFT), unsigned and at full width.
REQ-020 On a candidate at index k: latch best=in and idx=k, load hold count HOLD_LEN, enter TRACK.
REQ-021 In TRACK, on each valid sample:
- If in > best (strictly), replace best and idx; on a tie the earliest sample is kept.
- Decrement the hold count.
- The sample that brings the count to 0 is compared too.
REQ-022 When the hold count reaches 0, the next cycle SHALL assert peak_detected_o for exactly 1 cycle, with peak_idx_o=idx and peak_val_o=best, and the state returns to SEARCH.
REQ-023 After returning to SEARCH, the next valid sample may start a new candidate; the moving sum updates in every state.
REQ-024 peak_idx_o and peak_val_o SHALL hold their last reported values until the next report.
REQ-025 noise_avg_o SHALL update the cycle after each valid sample.

Reset
REQ-026 While reset_ni is low, regardless of clock:
- peak_detected_o, peak_idx_o, peak_val_o, noise_avg_o, the moving sum, the index counter, best, idx and the hold count are all 0.
- State is WARMUP.
REQ-027 Reset asserted mid-TRACK SHALL discard the candidate with no pulse emitted; after release, warmup restarts and indexing restarts at 0.

Configuration
REQ-028 Macro PSS_PEAK_MAX_HOLD_EN defined: TRACK state and hold logic are present, as in REQ-020..REQ-022.
REQ-029 Macro PSS_PEAK_MAX_HOLD_EN undefined: there is no TRACK state. A candidate at index k produces peak_detected_o in the next cycle with idx=k and val=in, then SEARCH continues; HOLD_LEN is ignored.

Verification (WINDOW_LEN=8, DETECTION_SHIFT=2, HOLD_LEN=4, CNT_DW=16, macro defined unless noted)
REQ-030 Constant 10 for 200 samples -> no peak_detected_o pulse; noise_avg_o=10 from index 7 onward.
REQ-031 Baseline 10 with index 20 = 100 -> one pulse in the cycle after index 24; idx=20, val=100.
REQ-032 Baseline 10 with index 20=100 and 22=150 -> idx=22, val=150.
REQ-033 Same as REQ-032 but index 22=100 (tie) -> idx=20.
REQ-034 Index 3 = 1000 during warmup -> no pulse; tvalid gaps inserted into the REQ-031 stream -> identical idx/val.
REQ-035 Reset pulsed at index 22 in TRACK -> no pulse and all outputs 0. Macro undefined with the REQ-031 stimulus -> pulse in the cycle after index 20, idx=20.

Source files
------------

// File: rtl/pss_peak_detector_if.sv
// Sample stream from the PSS correlator into the peak detector.
// The stream has no backpressure, so it carries only data and a valid strobe.
interface pss_peak_detector_if #(
  parameter int IN_DW = 24
);
  logic [IN_DW-1:0] tdata;
  logic             tvalid;

  modport master (output tdata, output tvalid);
  modport slave  (input  tdata, input  tvalid);
endinterface

// File: rtl/pss_peak_detector.sv
// PSS peak detector: moving-average noise floor, threshold candidate test and
// optional max-hold tracking window (enabled by macro PSS_PEAK_MAX_HOLD_EN).
module pss_peak_detector #(
  parameter int IN_DW           = 24,
  parameter int WINDOW_LEN      = 128,
  parameter int DETECTION_SHIFT = 4,
  parameter int HOLD_LEN        = 16,
  parameter int CNT_DW          = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  pss_peak_detector_if.slave   s_axis_in,
  output logic                 peak_detected_o,
  output logic [CNT_DW-1:0]    peak_idx_o,
  output logic [IN_DW-1:0]     peak_val_o,
  output logic [IN_DW-1:0]     noise_avg_o
);

  localparam int LOG2W   = $clog2(WINDOW_LEN);
  localparam int SUM_DW  = IN_DW + LOG2W;
  localparam int CMP_DW  = SUM_DW + DETECTION_SHIFT;
  localparam int HOLD_DW = $clog2(HOLD_LEN + 1);

`ifdef PSS_PEAK_MAX_HOLD_EN
  typedef enum logic [1:0] {WARMUP = 2'd0, SEARCH = 2'd1, TRACK = 2'd2} state_t;
`else
  typedef enum logic [1:0] {WARMUP = 2'd0, SEARCH = 2'd1} state_t;
`endif

  state_t              state_q, state_d;
  logic [CNT_DW-1:0]   cnt_q;
  logic [LOG2W-1:0]    wr_ptr_q;
  logic [SUM_DW-1:0]   sum_q, sum_next;
  logic [IN_DW-1:0]    best_q, best_d;
  logic [CNT_DW-1:0]   idx_q, idx_d;
  logic [HOLD_DW-1:0]  hold_q, hold_d;
  logic [IN_DW-1:0]    ring_q [WINDOW_LEN];
  logic [IN_DW-1:0]    in_data, oldest;
  logic                in_valid, candidate, report;
  logic [CNT_DW-1:0]   rep_idx;
  logic [IN_DW-1:0]    rep_val;
  logic [CMP_DW-1:0]   in_scaled, sum_scaled;

  assign in_data  = s_axis_in.tdata;
  assign in_valid = s_axis_in.tvalid;

  // The write slot always holds the sample leaving the window once warmup is done.
  assign oldest     = ring_q[wr_ptr_q];
  assign sum_next   = (state_q == WARMUP) ? sum_q + SUM_DW'(in_data)
                                          : sum_q + SUM_DW'(in_data) - SUM_DW'(oldest);
  assign in_scaled  = CMP_DW'({in_data, {LOG2W{1'b0}}});
  assign sum_scaled = CMP_DW'(sum_q) << DETECTION_SHIFT;
  assign candidate  = in_scaled > sum_scaled;

  always_ff @(posedge clk_i) begin
    if (in_valid) ring_q[wr_ptr_q] <= in_data;
  end

  always_comb begin
    state_d = state_q;
    best_d  = best_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    report  = 1'b0;
    rep_idx = peak_idx_o;
    rep_val = peak_val_o;
    if (in_valid) begin
      case (state_q)
        WARMUP: begin
          if (wr_ptr_q == LOG2W'(WINDOW_LEN - 1)) state_d = SEARCH;
        end
        SEARCH: begin
          if (candidate) begin
            best_d = in_data;
            idx_d  = cnt_q;
`ifdef PSS_PEAK_MAX_HOLD_EN
            hold_d  = HOLD_DW'(HOLD_LEN);
            state_d = TRACK;
`else
            report  = 1'b1;
            rep_idx = cnt_q;
            rep_val = in_data;
`endif
          end
        end
`ifdef PSS_PEAK_MAX_HOLD_EN
        TRACK: begin
          // Strict compare keeps the earliest sample on ties.
          if (in_data > best_q) begin
            best_d = in_data;
            idx_d  = cnt_q;
          end
          hold_d = hold_q - HOLD_DW'(1);
          if (hold_q == HOLD_DW'(1)) begin
            report  = 1'b1;
            rep_idx = idx_d;
            rep_val = best_d;
            state_d = SEARCH;
          end
        end
`endif
        default: state_d = WARMUP;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q         <= WARMUP;
      cnt_q           <= '0;
      wr_ptr_q        <= '0;
      sum_q           <= '0;
      best_q          <= '0;
      idx_q           <= '0;
      hold_q          <= '0;
      peak_detected_o <= 1'b0;
      peak_idx_o      <= '0;
      peak_val_o      <= '0;
      noise_avg_o     <= '0;
    end else begin
      state_q         <= state_d;
      best_q          <= best_d;
      idx_q           <= idx_d;
      hold_q          <= hold_d;
      peak_detected_o <= report;
      if (report) begin
        peak_idx_o <= rep_idx;
        peak_val_o <= rep_val;
      end
      if (in_valid) begin
        cnt_q       <= cnt_q + CNT_DW'(1);
        wr_ptr_q    <= wr_ptr_q + LOG2W'(1);
        sum_q       <= sum_next;
        noise_avg_o <= IN_DW'(sum_next >> LOG2W);
      end
    end
  end

endmodule

// File: tb/tb_pss_peak_detector.sv
// Self-checking bench for pss_peak_detector: directed scenarios plus a random
// stream, all compared against a window/queue based reference model.
module tb_pss_peak_detector;

  localparam int IN_DW           = 24;
  localparam int WINDOW_LEN      = 8;
  localparam int DETECTION_SHIFT = 2;
  localparam int HOLD_LEN        = 4;
  localparam int CNT_DW          = 16;

  logic                clk_i = 1'b0;
  logic                reset_ni = 1'b0;
  logic                peak_detected_o;
  logic [CNT_DW-1:0]   peak_idx_o;
  logic [IN_DW-1:0]    peak_val_o;
  logic [IN_DW-1:0]    noise_avg_o;

  pss_peak_detector_if #(.IN_DW(IN_DW)) s_axis_in ();

  pss_peak_detector #(
    .IN_DW(IN_DW), .WINDOW_LEN(WINDOW_LEN), .DETECTION_SHIFT(DETECTION_SHIFT),
    .HOLD_LEN(HOLD_LEN), .CNT_DW(CNT_DW)
  ) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .s_axis_in(s_axis_in),
    .peak_detected_o(peak_detected_o), .peak_idx_o(peak_idx_o),
    .peak_val_o(peak_val_o), .noise_avg_o(noise_avg_o)
  );

  always #5 clk_i = ~clk_i;

  int compared   = 0;
  int mismatched = 0;
  int pulse_cnt  = 0;

  // Reference model state: the last WINDOW_LEN samples and the peak bookkeeping.
  longint unsigned win[$];
  int              n_seen;
  bit              tracking;
  int              hold_left;
  longint unsigned m_best, m_idx;
  logic [31:0]     exp_pulse, exp_idx, exp_val, exp_avg;

  task automatic checkValue(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(string tag);
    if (peak_detected_o === 1'b1) pulse_cnt++;
    checkValue({tag, "_pulse"}, 32'(peak_detected_o), exp_pulse);
    checkValue({tag, "_idx"},   32'(peak_idx_o),      exp_idx);
    checkValue({tag, "_val"},   32'(peak_val_o),      exp_val);
    checkValue({tag, "_avg"},   32'(noise_avg_o),     exp_avg);
  endtask

  task automatic modelReset();
    win.delete();
    n_seen = 0; tracking = 0; hold_left = 0; m_best = 0; m_idx = 0;
    exp_pulse = 0; exp_idx = 0; exp_val = 0; exp_avg = 0;
  endtask

  task automatic modelStep(bit v, longint unsigned d);
    longint unsigned sum, idx;
    bit warm;
    exp_pulse = 0;
    if (!v) return;
    sum = 0;
    foreach (win[i]) sum += win[i];
    warm = (n_seen >= WINDOW_LEN);
    idx  = longint'(n_seen) % (64'd1 << CNT_DW);
`ifdef PSS_PEAK_MAX_HOLD_EN
    if (tracking) begin
      if (d > m_best) begin m_best = d; m_idx = idx; end
      hold_left--;
      if (hold_left == 0) begin
        tracking = 0; exp_pulse = 1; exp_idx = 32'(m_idx); exp_val = 32'(m_best);
      end
    end else if (warm && (d * WINDOW_LEN > sum * (64'd1 << DETECTION_SHIFT))) begin
      tracking = 1; m_best = d; m_idx = idx; hold_left = HOLD_LEN;
    end
`else
    if (warm && (d * WINDOW_LEN > sum * (64'd1 << DETECTION_SHIFT))) begin
      exp_pulse = 1; exp_idx = 32'(idx); exp_val = 32'(d);
    end
`endif
    win.push_back(d);
    if (win.size() > WINDOW_LEN) void'(win.pop_front());
    sum = 0;
    foreach (win[i]) sum += win[i];
    exp_avg = 32'(sum / WINDOW_LEN);
    n_seen++;
  endtask

  task automatic applyStimulus(bit v, longint unsigned d, string tag);
    s_axis_in.tvalid = v;
    s_axis_in.tdata  = IN_DW'(d);
    @(posedge clk_i);
    #1;
    modelStep(v, d);
    checkOutput(tag);
  endtask

  task automatic applyReset();
    s_axis_in.tvalid = 1'b0;
    s_axis_in.tdata  = '0;
    #2;
    reset_ni = 1'b0;
    modelReset();
    #1;
    checkOutput("reset_async");
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset_held");
    reset_ni = 1'b1;
    pulse_cnt = 0;
  endtask

  // Baseline of 10 with up to two spiked indices; optional random idle gaps.
  task automatic runBaseline(int n, int i1, int v1, int i2, int v2, bit gaps, string tag);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) applyStimulus(0, $urandom_range(0, 5000), tag);
      applyStimulus(1, (i == i1) ? v1 : (i == i2) ? v2 : 10, tag);
    end
  endtask

  initial begin
    s_axis_in.tvalid = 1'b0;
    s_axis_in.tdata  = '0;
    modelReset();
    applyReset();

    runBaseline(200, -1, 0, -1, 0, 0, "const10");
    checkValue("const10_pulses", 32'(pulse_cnt), 0);
    checkValue("const10_avg", 32'(noise_avg_o), 10);

    applyReset();
    runBaseline(40, 20, 100, -1, 0, 0, "single");
    checkValue("single_pulses", 32'(pulse_cnt), 1);
    checkValue("single_idx", 32'(peak_idx_o), 20);
    checkValue("single_val", 32'(peak_val_o), 100);

    applyReset();
    runBaseline(40, 20, 100, 22, 150, 0, "bigger");
    checkValue("bigger_idx", 32'(peak_idx_o), 22);
    checkValue("bigger_val", 32'(peak_val_o), 150);

    applyReset();
    runBaseline(40, 20, 100, 22, 100, 0, "tie");
`ifdef PSS_PEAK_MAX_HOLD_EN
    checkValue("tie_idx", 32'(peak_idx_o), 20);
`else
    checkValue("tie_idx", 32'(peak_idx_o), 22);
`endif

    applyReset();
    runBaseline(40, 3, 1000, -1, 0, 0, "warmup_spike");
    checkValue("warmup_spike_pulses", 32'(pulse_cnt), 0);

    applyReset();
    runBaseline(40, 20, 100, -1, 0, 1, "gaps");
    checkValue("gaps_pulses", 32'(pulse_cnt), 1);
    checkValue("gaps_idx", 32'(peak_idx_o), 20);
    checkValue("gaps_val", 32'(peak_val_o), 100);

    applyReset();
    runBaseline(22, 20, 100, -1, 0, 0, "pre_reset");
    applyReset();
    runBaseline(30, -1, 0, -1, 0, 0, "post_reset");
    checkValue("post_reset_pulses", 32'(pulse_cnt), 0);
    checkValue("post_reset_idx", 32'(peak_idx_o), 0);

    applyReset();
    for (int i = 0; i < 400; i++) begin
      bit v;
      longint unsigned d;
      v = ($urandom_range(0, 99) < 80);
      d = ($urandom_range(0, 99) < 6) ? $urandom_range(50, 400) : $urandom_range(5, 20);
      applyStimulus(v, d, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
